seg_scan_mux: RTL and testbench



---
 rtl/seg_scan_mux_if.sv | 36 +++
 rtl/seg_scan_mux.sv | 106 ++++++++++
 tb/tb_seg_scan_mux.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_mux_if.sv
// Bus between a word producer and the seg_scan_mux display scanner.
// The producer side (master) offers hex words with a valid/ready handshake
// and selects blanking. The scanner side (slave) returns the decoder nibble,
// the active-low digit enables and the frame pulse.
interface seg_scan_mux_if #(
    parameter int NUM_DIGITS = 4,
    parameter int DATA_W     = 16
);
    logic [DATA_W-1:0]     data_in;
    logic                  data_valid;
    logic                  data_ready;
    logic                  blank_en;
    logic [3:0]            digit_nibble;
    logic [NUM_DIGITS-1:0] anode_n;
    logic                  frame_start;

    modport master (
        output data_in,
        output data_valid,
        output blank_en,
        input  data_ready,
        input  digit_nibble,
        input  anode_n,
        input  frame_start
    );

    modport slave (
        input  data_in,
        input  data_valid,
        input  blank_en,
        output data_ready,
        output digit_nibble,
        output anode_n,
        output frame_start
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan controller for a common-anode 7-segment bank.
// Incoming words wait in a one-entry pending buffer and are committed to the
// display register only at frame boundaries, so a frame never tears. Each
// digit stays enabled for REFRESH_DIV clocks; digit 0 is the rightmost.
// DATA_W has to equal 4*NUM_DIGITS (one nibble per digit).
module seg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int DATA_W      = 16,
    parameter int REFRESH_DIV = 50000
) (
    input  logic          clk,
    input  logic          rst_n,
    seg_scan_mux_if.slave bus
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(REFRESH_DIV - 1);

    // Scan and buffer state
    logic [DIV_W-1:0]      r_div_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_W-1:0]     r_disp;
    logic [DATA_W-1:0]     r_pend;
    logic                  r_pend_full;

    // Registered outputs
    logic [3:0]            r_nibble;
    logic [NUM_DIGITS-1:0] r_anode_n;
    logic                  r_frame_edge;
    logic                  r_frame_start;

    // Combinational helpers
    logic                  w_tick;
    logic                  w_frame;
    logic                  w_capture;
    logic [NUM_DIGITS-1:0] w_upper_zero;
    logic                  w_blank_cur;
    logic [3:0]            w_nibble;
    logic [NUM_DIGITS-1:0] w_onehot;

    assign w_tick    = (r_div_cnt == LAST_DIV);
    assign w_frame   = w_tick && (r_idx == LAST_IDX);
    // Ready comes from registered state only, never from data_valid.
    assign w_capture = bus.data_valid && !r_pend_full;

    // w_upper_zero[k] is set when nibbles k..NUM_DIGITS-1 of the display are
    // all zero, i.e. digit k would be a leading zero.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_zero
        assign w_upper_zero[k] = (r_disp[DATA_W-1:4*k] == '0);
    end

    // Digit 0 is never blanked so a zero value still shows a single "0".
    assign w_blank_cur = bus.blank_en && (r_idx != '0) && w_upper_zero[r_idx];
    assign w_nibble    = r_disp[{r_idx, 2'b00} +: 4];
    assign w_onehot    = NUM_DIGITS'(1) << r_idx;

    // Refresh divider, digit index, pending buffer capture and frame commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt   <= '0;
            r_idx       <= '0;
            r_disp      <= '0;
            r_pend      <= '0;
            r_pend_full <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;

            if (w_tick) begin
                r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
            end

            // Commit and capture cannot coincide: capture needs an empty buffer.
            if (w_frame && r_pend_full) begin
                r_disp      <= r_pend;
                r_pend_full <= 1'b0;
            end else if (w_capture) begin
                r_pend      <= bus.data_in;
                r_pend_full <= 1'b1;
            end
        end
    end

    // Output registers, one clock behind idx/disp. The boundary is delayed
    // once more so the frame pulse coincides with digit 0 appearing on anode_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nibble      <= 4'h0;
            r_anode_n     <= '1;
            r_frame_edge  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_nibble      <= w_nibble;
            r_anode_n     <= w_blank_cur ? '1 : ~w_onehot;
            r_frame_edge  <= w_frame;
            r_frame_start <= r_frame_edge;
        end
    end

    assign bus.data_ready   = ~r_pend_full;
    assign bus.digit_nibble = r_nibble;
    assign bus.anode_n      = r_anode_n;
    assign bus.frame_start  = r_frame_start;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed self-checking bench for seg_scan_mux. A slow instance
// (REFRESH_DIV=4) carries the load, blanking, backpressure and reset
// scenarios; a fast instance (REFRESH_DIV=1) checks per-cycle scanning.
`timescale 1ns/1ps
module tb_seg_scan_mux;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   assertCount = 0;
    int   failCount   = 0;

    seg_scan_mux_if #(.NUM_DIGITS(4), .DATA_W(16)) bus ();
    seg_scan_mux_if #(.NUM_DIGITS(4), .DATA_W(16)) busFast ();

    seg_scan_mux #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    seg_scan_mux #(.NUM_DIGITS(4), .DATA_W(16), .REFRESH_DIV(1)) dutFast (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busFast)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard stop in case something upstream never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected end before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic v);
        bus.data_in    = d;
        bus.data_valid = v;
    endtask

    // Advance until the next frame_start pulse, bounded.
    task automatic waitFrame(output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (bus.frame_start !== 1'b1 && steps < 64);
        checkOutput("frameFound", 32'(bus.frame_start), 32'd1);
    endtask

    // Check a whole frame from its frame_start cycle. anodes packs the four
    // expected enables as {an3, an2, an1, an0}. Ends on the frame's last cycle.
    task automatic checkFrame(input logic [15:0] value, input logic [15:0] anodes,
                              input string tag);
        int d;
        for (int i = 0; i < 16; i++) begin
            d = i / 4;
            if (i > 0) step();
            checkOutput($sformatf("%s.anode%0d", tag, d), 32'(bus.anode_n),
                        32'(anodes[4*d +: 4]));
            checkOutput($sformatf("%s.nibble%0d", tag, d), 32'(bus.digit_nibble),
                        32'(value[4*d +: 4]));
            checkOutput($sformatf("%s.fs%0d_%0d", tag, d, i % 4), 32'(bus.frame_start),
                        32'(i == 0));
        end
    endtask

    // Main directed sequence.
    initial begin
        int steps;
        logic [3:0] fastAn [4];
        fastAn = '{4'hE, 4'hD, 4'hB, 4'h7};

        applyStimulus(16'h0000, 1'b0);
        bus.blank_en       = 1'b0;
        busFast.data_in    = '0;
        busFast.data_valid = 1'b0;
        busFast.blank_en   = 1'b0;

        // Reset and idle rotation
        stepN(3);
        checkOutput("rst.anode", 32'(bus.anode_n), 32'hF);
        checkOutput("rst.nibble", 32'(bus.digit_nibble), 32'h0);
        checkOutput("rst.ready", 32'(bus.data_ready), 32'd1);
        checkOutput("rst.fs", 32'(bus.frame_start), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("rel.anode", 32'(bus.anode_n), 32'hE);
        checkOutput("rel.nibble", 32'(bus.digit_nibble), 32'h0);
        checkOutput("rel.fs", 32'(bus.frame_start), 32'd0);
        waitFrame(steps);
        checkOutput("rel.frameDelay", 32'(steps), 32'd16);
        checkFrame(16'h0000, 16'h7BDE, "idle");

        // Load 12A7: held in pend until the boundary
        waitFrame(steps);
        applyStimulus(16'h12A7, 1'b1);
        step();
        applyStimulus(16'h12A7, 1'b0);
        checkOutput("load.readyLow", 32'(bus.data_ready), 32'd0);
        for (int i = 0; i < 13; i++) begin
            step();
            checkOutput("load.holdNibble", 32'(bus.digit_nibble), 32'h0);
            checkOutput("load.holdReady", 32'(bus.data_ready), 32'd0);
        end
        step();
        checkOutput("load.readyBack", 32'(bus.data_ready), 32'd1);
        checkOutput("load.lastOld", 32'(bus.digit_nibble), 32'h0);
        step();
        checkFrame(16'h12A7, 16'h7BDE, "load");

        // Leading-zero blanking
        bus.blank_en = 1'b1;
        waitFrame(steps);
        applyStimulus(16'h0051, 1'b1);
        step();
        applyStimulus(16'h0051, 1'b0);
        waitFrame(steps);
        checkFrame(16'h0051, 16'hFFDE, "blank51");
        waitFrame(steps);
        applyStimulus(16'h0000, 1'b1);
        step();
        applyStimulus(16'h0000, 1'b0);
        waitFrame(steps);
        checkFrame(16'h0000, 16'hFFFE, "blank0");
        bus.blank_en = 1'b0;
        waitFrame(steps);
        checkFrame(16'h0000, 16'h7BDE, "noblank0");

        // Backpressure: second word refused until the commit frees the buffer
        waitFrame(steps);
        applyStimulus(16'h1111, 1'b1);
        step();
        applyStimulus(16'h2222, 1'b1);
        checkOutput("bp.readyLow1", 32'(bus.data_ready), 32'd0);
        step();
        checkOutput("bp.readyLow2", 32'(bus.data_ready), 32'd0);
        stepN(12);
        checkOutput("bp.readyLow14", 32'(bus.data_ready), 32'd0);
        step();
        checkOutput("bp.readyCommit", 32'(bus.data_ready), 32'd1);
        step();
        checkOutput("bp.accepted", 32'(bus.data_ready), 32'd0);
        applyStimulus(16'h2222, 1'b0);
        checkFrame(16'h1111, 16'h7BDE, "bp1111");
        step();
        checkFrame(16'h2222, 16'h7BDE, "bp2222");

        // Capture on the boundary cycle itself
        waitFrame(steps);
        stepN(14);
        applyStimulus(16'hBEEF, 1'b1);
        step();
        applyStimulus(16'hBEEF, 1'b0);
        checkOutput("edge.captured", 32'(bus.data_ready), 32'd0);
        checkOutput("edge.lastDigit", 32'(bus.anode_n), 32'h7);
        step();
        checkFrame(16'h2222, 16'h7BDE, "edgeOld");
        checkOutput("edge.readyBack", 32'(bus.data_ready), 32'd1);
        step();
        checkFrame(16'hBEEF, 16'h7BDE, "edgeNew");

        // Asynchronous reset mid-scan with a pending word
        waitFrame(steps);
        applyStimulus(16'h1234, 1'b1);
        step();
        applyStimulus(16'h1234, 1'b0);
        checkOutput("arst.pendFull", 32'(bus.data_ready), 32'd0);
        stepN(7);
        checkOutput("arst.digit2", 32'(bus.anode_n), 32'hB);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst.anode", 32'(bus.anode_n), 32'hF);
        checkOutput("arst.nibble", 32'(bus.digit_nibble), 32'h0);
        checkOutput("arst.ready", 32'(bus.data_ready), 32'd1);
        checkOutput("arst.fastAnode", 32'(busFast.anode_n), 32'hF);
        stepN(2);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("arst.relAnode", 32'(bus.anode_n), 32'hE);
        checkOutput("arst.fastRel", 32'(busFast.anode_n), 32'hE);
        checkOutput("arst.fastRelFs", 32'(busFast.frame_start), 32'd0);

        // Fast instance advances a digit every clock
        for (int i = 1; i <= 12; i++) begin
            step();
            checkOutput($sformatf("fast.anode%0d", i), 32'(busFast.anode_n),
                        32'(fastAn[i % 4]));
            checkOutput($sformatf("fast.fs%0d", i), 32'(busFast.frame_start),
                        32'(i % 4 == 0));
        end

        // Pending word was discarded by reset: display stays zero
        waitFrame(steps);
        checkFrame(16'h0000, 16'h7BDE, "arstDisp");
        waitFrame(steps);
        checkFrame(16'h0000, 16'h7BDE, "arstDisp2");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertCount, failCount);
        $finish;
    end

endmodule
